// File: rtl/vga_scope_pkg.sv
// vga_scope_pkg
//   Shared definitions for the scope raster engine: default 640x480@60 timing,
//   RGB444 pixel type, per-channel trace colours, graticule colour and the
//   counter width helper used to size h/v counters and the divider.
package vga_scope_pkg;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FP      = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BP      = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FP      = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BP      = 33;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t GRID_RGB = '{r: 4'h4, g: 4'h4, b: 4'h4};

   // Bits needed to hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Trace colour for channel k (0..3).
   function automatic rgb_t ch_rgb(input int unsigned k);
      case (k)
         0:       return '{r: 4'hF, g: 4'hF, b: 4'h0};
         1:       return '{r: 4'h0, g: 4'hF, b: 4'hF};
         2:       return '{r: 4'hF, g: 4'h0, b: 4'hF};
         default: return '{r: 4'h0, g: 4'hF, b: 4'h0};
      endcase
   endfunction

endpackage

// File: rtl/vga_scope_raster_timing.sv
// vga_timing_core
//   Pixel-rate clock-enable divider and free-running h/v raster counters with
//   raw (undelayed, polarity-free) sync and blank flags.
//   Ports: clk, reset (async, active-high) | pix_ce: one clk per pixel |
//          h_count/v_count: raster position | hs_act/vs_act: inside sync pulse |
//          blank_raw: outside the visible area.
module vga_timing_core
   import vga_scope_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned HW        = cnt_w(H_VISIBLE + H_FP + H_SYNC + H_BP),
   parameter int unsigned VW        = cnt_w(V_VISIBLE + V_FP + V_SYNC + V_BP)
)(
   input  logic          clk,
   input  logic          reset,
   output logic          pix_ce,
   output logic [HW-1:0] h_count,
   output logic [VW-1:0] v_count,
   output logic          hs_act,
   output logic          vs_act,
   output logic          blank_raw
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW      = cnt_w(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

   logic [DW-1:0] div;

   // With CLK_DIV == 1 div stays 0 and pix_ce is permanently high.
   assign pix_ce = (div == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       div <= '0;
      else if (pix_ce) div <= '0;
      else             div <= div + DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (pix_ce) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
         end else begin
            h_count <= h_count + HW'(1);
         end
      end
   end

   assign hs_act    = (32'(h_count) >= H_VISIBLE + H_FP) &&
                      (32'(h_count) <  H_VISIBLE + H_FP + H_SYNC);
   assign vs_act    = (32'(v_count) >= V_VISIBLE + V_FP) &&
                      (32'(v_count) <  V_VISIBLE + V_FP + V_SYNC);
   assign blank_raw = (32'(h_count) >= H_VISIBLE) || (32'(v_count) >= V_VISIBLE);

endmodule

// File: rtl/vga_scope_raster.sv
// vga_scope_raster
//   VGA raster engine for the scope display. Raster position is delayed
//   FETCH_LAT pixel ticks to line up with sample RAM data, then the pixel
//   colour (traces over optional graticule) is registered one more tick.
//   Ports: clk, reset (async, active-high) | ch_en, grid_en: per-pixel draw
//          controls | sample_x -> RAM column, sample_data <- NUM_CH samples |
//          hsync/vsync/blank/red_out/green_out/blue_out: DAC side |
//          frame_start: 1-clk pulse with pixel (0,0) | h_count/v_count: raw
//          raster counters.
module vga_scope_raster
   import vga_scope_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned SAMPLE_W  = 9,
   parameter int unsigned FETCH_LAT = 2,
   parameter int unsigned GRID_STEP = 64
)(
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic [NUM_CH-1:0]                                    ch_en,
   input  logic                                                 grid_en,
   output logic [cnt_w(H_VISIBLE+H_FP+H_SYNC+H_BP)-1:0]         sample_x,
   input  logic [NUM_CH*SAMPLE_W-1:0]                           sample_data,
   output logic                                                 hsync,
   output logic                                                 vsync,
   output logic                                                 blank,
   output logic [3:0]                                           red_out,
   output logic [3:0]                                           green_out,
   output logic [3:0]                                           blue_out,
   output logic                                                 frame_start,
   output logic [cnt_w(H_VISIBLE+H_FP+H_SYNC+H_BP)-1:0]         h_count,
   output logic [cnt_w(V_VISIBLE+V_FP+V_SYNC+V_BP)-1:0]         v_count
);

   localparam int unsigned HW = cnt_w(H_VISIBLE + H_FP + H_SYNC + H_BP);
   localparam int unsigned VW = cnt_w(V_VISIBLE + V_FP + V_SYNC + V_BP);

   typedef struct packed {
      logic          valid;
      logic [HW-1:0] x;
      logic [VW-1:0] y;
      logic          hs;
      logic          vs;
      logic          blank;
   } tap_t;

   // valid keeps the reset-filled (0,0) entries from raising frame_start.
   localparam tap_t TAP_RST = '{valid: 1'b0, x: '0, y: '0, hs: 1'b0, vs: 1'b0, blank: 1'b1};

   logic pix_ce, hs_act, vs_act, blank_raw;
   tap_t stage0, tap;
   tap_t pipe [FETCH_LAT];
   rgb_t pix_rgb;
   logic hit;
   int unsigned row, samp;

   vga_timing_core #(
      .H_VISIBLE (H_VISIBLE),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VISIBLE (V_VISIBLE),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .CLK_DIV   (CLK_DIV),
      .HW        (HW),
      .VW        (VW)
   ) u_timing (
      .clk       (clk),
      .reset     (reset),
      .pix_ce    (pix_ce),
      .h_count   (h_count),
      .v_count   (v_count),
      .hs_act    (hs_act),
      .vs_act    (vs_act),
      .blank_raw (blank_raw)
   );

   assign sample_x = h_count;
   assign stage0   = '{valid: 1'b1, x: h_count, y: v_count, hs: hs_act, vs: vs_act, blank: blank_raw};
   assign tap      = pipe[FETCH_LAT-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FETCH_LAT; i++) pipe[i] <= TAP_RST;
      end else if (pix_ce) begin
         pipe[0] <= stage0;
         for (int unsigned i = 1; i < FETCH_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Screen row 0 is the top line, sample value 0 the bottom one.
   always_comb begin
      pix_rgb = '0;
      hit     = 1'b0;
      samp    = 0;
      row     = V_VISIBLE - 1 - 32'(tap.y);
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         samp = 32'(sample_data[k*SAMPLE_W +: SAMPLE_W]);
         if (!hit && ch_en[k] && samp < V_VISIBLE && samp == row) begin
            hit     = 1'b1;
            pix_rgb = ch_rgb(k);
         end
      end
      if (!hit && grid_en &&
          (((32'(tap.x) & (GRID_STEP - 1)) == 0) || ((32'(tap.y) & (GRID_STEP - 1)) == 0) ||
           (32'(tap.x) == H_VISIBLE - 1) || (32'(tap.y) == V_VISIBLE - 1)))
         pix_rgb = GRID_RGB;
      if (tap.blank) pix_rgb = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         blank       <= 1'b1;
         red_out     <= '0;
         green_out   <= '0;
         blue_out    <= '0;
         frame_start <= 1'b0;
      end else begin
         // Outputs only change on pix_ce, so gating with it yields a single-clk pulse.
         frame_start <= pix_ce && tap.valid && (tap.x == '0) && (tap.y == '0);
         if (pix_ce) begin
            hsync                           <= tap.hs ? HSYNC_POL : ~HSYNC_POL;
            vsync                           <= tap.vs ? VSYNC_POL : ~VSYNC_POL;
            blank                           <= tap.blank;
            {red_out, green_out, blue_out}  <= pix_rgb;
         end
      end
   end

endmodule

// File: tb/tb_vga_scope_raster.sv
// tb_vga_scope_raster
//   Directed bench on a shrunken raster (24x16 total, 16x12 visible, grid 4).
//   u_dut0 runs CLK_DIV=2, u_dut1 runs CLK_DIV=1; sel picks the one observed.
module tb_vga_scope_raster;

   localparam int HV = 16, HFP = 2, HSY = 4, HBP = 2;
   localparam int VV = 12, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HV + HFP + HSY + HBP;
   localparam int VT = VV + VFP + VSY + VBP;
   localparam int FL = 2, GS = 4, SW = 9;

   logic        clk, reset, grid_en, sel;
   logic [1:0]  ch_en;
   logic [8:0]  s0, s1;
   logic [17:0] sample_data;
   int          cd;
   int          nvec = 0;
   int          nerr = 0;

   logic       d0_hs, d0_vs, d0_bl, d0_fs, d1_hs, d1_vs, d1_bl, d1_fs;
   logic [3:0] d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;
   logic [4:0] d0_sx, d0_h, d1_sx, d1_h;
   logic [3:0] d0_v, d1_v;

   logic       obs_hs, obs_vs, obs_bl, obs_fs;
   logic [3:0] obs_r, obs_g, obs_b, obs_v;
   logic [4:0] obs_sx, obs_h;

   assign sample_data = {s1, s0};
   assign obs_hs = sel ? d1_hs : d0_hs;
   assign obs_vs = sel ? d1_vs : d0_vs;
   assign obs_bl = sel ? d1_bl : d0_bl;
   assign obs_fs = sel ? d1_fs : d0_fs;
   assign obs_r  = sel ? d1_r  : d0_r;
   assign obs_g  = sel ? d1_g  : d0_g;
   assign obs_b  = sel ? d1_b  : d0_b;
   assign obs_sx = sel ? d1_sx : d0_sx;
   assign obs_h  = sel ? d1_h  : d0_h;
   assign obs_v  = sel ? d1_v  : d0_v;

   vga_scope_raster #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .NUM_CH(2),
      .SAMPLE_W(SW), .FETCH_LAT(FL), .GRID_STEP(GS)
   ) u_dut0 (
      .clk(clk), .reset(reset), .ch_en(ch_en), .grid_en(grid_en),
      .sample_x(d0_sx), .sample_data(sample_data), .hsync(d0_hs), .vsync(d0_vs),
      .blank(d0_bl), .red_out(d0_r), .green_out(d0_g), .blue_out(d0_b),
      .frame_start(d0_fs), .h_count(d0_h), .v_count(d0_v)
   );

   vga_scope_raster #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .NUM_CH(2),
      .SAMPLE_W(SW), .FETCH_LAT(FL), .GRID_STEP(GS)
   ) u_dut1 (
      .clk(clk), .reset(reset), .ch_en(ch_en), .grid_en(grid_en),
      .sample_x(d1_sx), .sample_data(sample_data), .hsync(d1_hs), .vsync(d1_vs),
      .blank(d1_bl), .red_out(d1_r), .green_out(d1_g), .blue_out(d1_b),
      .frame_start(d1_fs), .h_count(d1_h), .v_count(d1_v)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // {frame_start, hsync, vsync, blank, r, g, b} expected for output pixel (x,y).
   function automatic logic [15:0] exp_pix(input int x, input int y);
      logic       hs, vs, bl, fs;
      logic [11:0] c;
      int          row;
      fs  = (x == 0) && (y == 0);
      hs  = !((x >= HV + HFP) && (x < HV + HFP + HSY));
      vs  = !((y >= VV + VFP) && (y < VV + VFP + VSY));
      bl  = (x >= HV) || (y >= VV);
      c   = 12'h000;
      row = VV - 1 - y;
      if (!bl) begin
         if (ch_en[0] && int'(s0) == row)      c = 12'hFF0;
         else if (ch_en[1] && int'(s1) == row) c = 12'h0FF;
         else if (grid_en && (x % GS == 0 || y % GS == 0 || x == HV - 1 || y == VV - 1))
            c = 12'h444;
      end
      return {fs, hs, vs, bl, c};
   endfunction

   function automatic logic sync_sig(input int which);
      return (which == 0) ? obs_hs : obs_vs;
   endfunction

   task automatic reset_and_latency(input string tag);
      int   n;
      logic seen;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check({tag, "_rst_out"}, 32'({obs_fs, obs_hs, obs_vs, obs_bl, obs_r, obs_g, obs_b}),
            32'({1'b0, 1'b1, 1'b1, 1'b1, 12'h000}));
      check({tag, "_rst_cnt"}, 32'({obs_sx, obs_h, obs_v}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         seen = obs_fs;
      end
      check({tag, "_latency"}, 32'(n), 32'((FL + 1) * cd));
      check({tag, "_blank_at_fs"}, 32'(obs_bl), 32'd0);
   endtask

   task automatic measure_sync(input int which, output int low, output int per);
      logic prev, cur;
      bit   hi;
      int   n;
      cur = sync_sig(which);
      prev = cur;
      n = 0;
      while (!(prev && !cur) && n < 4000) begin
         @(negedge clk);
         prev = cur;
         cur = sync_sig(which);
         n++;
      end
      low = 0;
      per = 0;
      hi = 1'b0;
      while (per < 4000) begin
         cur = sync_sig(which);
         if (!cur && hi) break;
         if (!cur) low++;
         else      hi = 1'b1;
         per++;
         @(negedge clk);
      end
   endtask

   task automatic frame_period(output int per);
      int n;
      n = 0;
      @(negedge clk);
      while (!obs_fs && n < 4000) begin
         @(negedge clk);
         n++;
      end
      per = 0;
      do begin
         @(negedge clk);
         per++;
      end while (!obs_fs && per < 4000);
   endtask

   task automatic timing_checks(input string tag);
      int low, per;
      measure_sync(0, low, per);
      check({tag, "_hs_low"}, 32'(low), 32'(HSY * cd));
      check({tag, "_hs_per"}, 32'(per), 32'(HT * cd));
      measure_sync(1, low, per);
      check({tag, "_vs_low"}, 32'(low), 32'(VSY * HT * cd));
      check({tag, "_vs_per"}, 32'(per), 32'(VT * HT * cd));
      frame_period(per);
      check({tag, "_frame_per"}, 32'(per), 32'(VT * HT * cd));
   endtask

   task automatic scan_frame(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!obs_fs && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_fs_seen"}, 32'(obs_fs), 32'd1);
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            check($sformatf("%s_x%0d_y%0d", tag, x, y),
                  32'({obs_fs, obs_hs, obs_vs, obs_bl, obs_r, obs_g, obs_b}),
                  32'(exp_pix(x, y)));
            repeat (cd) @(negedge clk);
         end
      end
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      sel     = 1'b0;
      cd      = 2;
      ch_en   = 2'b00;
      grid_en = 1'b0;
      s0      = 9'd0;
      s1      = 9'd0;

      // CLK_DIV = 2: reset state, latency, sync/frame timing
      reset_and_latency("d2");
      timing_checks("d2");

      // single trace, ch1 disabled even though its sample would match row 11
      ch_en = 2'b01; s0 = 9'd6; s1 = 9'd0;
      scan_frame("ch0_only");

      // both channels on the same row: ch0 wins; then ch1 alone
      ch_en = 2'b11; s0 = 9'd3; s1 = 9'd3;
      scan_frame("both_same");
      ch_en = 2'b10;
      scan_frame("ch1_only");

      // clipped samples, then graticule, then traces over graticule
      ch_en = 2'b11; s0 = 9'd12; s1 = 9'd511;
      scan_frame("clipped");
      grid_en = 1'b1;
      scan_frame("grid");
      s0 = 9'd2; s1 = 9'd7;
      scan_frame("grid_traces");

      // mid-frame reset
      n = 0;
      while (obs_v != 4'd6 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("mid_wait_line6", 32'(obs_v), 32'd6);
      reset_and_latency("mid");
      timing_checks("mid");
      scan_frame("mid_frame");

      // CLK_DIV = 1 re-run
      sel = 1'b1;
      cd  = 1;
      reset_and_latency("d1");
      timing_checks("d1");
      scan_frame("d1_frame");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
